wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage and architectural register file in one block; it consumes the MEM/WB pipeline register outputs.
- Selects the write-back data (ALU result or load data) and commits it to a 32x32 register file.
- Serves the two ID-stage read ports.
- Keeps a retired-write counter for debug and performance.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- CNT_W, 32, width of retired-write counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- wb_MemtoReg  input  1  1 selects wb_RD, 0 selects wb_ALUout.
- wb_RegWrite  input  1  write enable from MEM/WB.
- wb_ALUout  input  DATA_W  ALU result from MEM/WB.
- wb_RD  input  DATA_W  data-memory read data from MEM/WB.
- wb_wn  input  ADDR_W  destination register index.
- rs_addr  input  ADDR_W  read port A index.
- rt_addr  input  ADDR_W  read port B index.
- rs_data  output  DATA_W  read port A data (combinational).
- rt_data  output  DATA_W  read port B data (combinational).
- wb_data  output  DATA_W  selected write-back value (combinational, for EX forwarding).
- wb_commit  output  1  registered; 1 for one cycle after a committed write.
- retire_cnt  output  CNT_W  registered count of committed writes.

Behaviour:
- Write-back select: wb_data = wb_MemtoReg ? wb_RD : wb_ALUout. Pure mux, no latency.
- Commit condition: commit = wb_RegWrite && (wb_wn != 0).
- Register update: on posedge clk with !rst and commit, regs[wb_wn] <= wb_data. Writes to index 0 are discarded.
- Register 0: reads as 0 always, regardless of any write attempt.
- Reads: rs_data = regs[rs_addr] and rt_data = regs[rt_addr], combinational, with index 0 returning 0.
- Read/write collision: behaviour when a read index equals wb_wn in the same cycle is set by REGFILE_BYPASS_EN (see Optional Feature).
- wb_commit: registered; equals the previous cycle's commit.
- retire_cnt: increments by 1 on each cycle with commit. Wraps from 2**CNT_W-1 to 0 with no saturation and no flag.
- Reset (synchronous, rst=1 at posedge):
  - all 32 registers cleared to 0;
  - wb_commit=0, retire_cnt=0;
  - any write presented in that cycle is dropped.
- Reset mid-stream: the first commit is possible on the first posedge with rst=0.
- During reset, rs_data and rt_data reflect register contents, which read 0 from the cycle after reset.
- X-handling: wb_wn and wb_MemtoReg are don't-care when wb_RegWrite=0. They must never cause a write.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If commit && rs_addr==wb_wn (index nonzero), rs_data = wb_data the same cycle. Same rule for rt. This removes the WB-to-ID hazard.
- Not defined: reads return stored contents only. A same-cycle collision returns the old value and the new value is visible from the next cycle. The hazard unit must then stall or forward externally.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and ADDR_W constants;
  - REG_ZERO index constant (0);
  - wb_sel enum (WB_ALU=0, WB_MEM=1) used by control and here.
- One natural sub-module: regfile_core, holding the storage array, the two read ports, the zero-register rule and the bypass option.
- The top holds the write-back mux, commit logic, wb_commit and retire_cnt.

Test Plan:
- Reset then read all indices -> rs_data=rt_data=0 for every index; retire_cnt=0; wb_commit=0.
- RegWrite=1, MemtoReg=0, ALUout=0x0000_1234, RD=0xDEAD_BEEF, wn=5, then read rs=5 next cycle -> 0x0000_1234; wb_commit=1 for one cycle; retire_cnt=1.
- Same but MemtoReg=1, wn=6 -> regs[6]=0xDEAD_BEEF; wb_data=0xDEAD_BEEF in the write cycle.
- Write to index 0 with ALUout=0xFFFF_FFFF, RegWrite=1 -> rs=0 reads 0; retire_cnt unchanged; wb_commit stays 0.
- Same-cycle write wn=7 value 0xA5A5_A5A5 with rs=rt=7 -> with REGFILE_BYPASS_EN: 0xA5A5_A5A5 that cycle. Without: old value that cycle, 0xA5A5_A5A5 the next.
- Preload retire_cnt path to 2**CNT_W-1 (CNT_W=4 build), one commit -> retire_cnt=0. Then assert rst together with a commit to wn=3 -> regs[3]=0 and retire_cnt=0 after that edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-back source select encoding,
// used by control and by the write-back / register-file block.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_t;

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural register file: storage, two combinational read ports, hardwired zero register.
// REGFILE_BYPASS_EN adds a write-through path from the write port to both read ports.
module regfile_core #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);
    import cpu_pkg::*;

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [ADDR_W-1:0] rd_addr  [2];
    logic              wr_en;

    // Index 0 is rejected here as well so the zero register never holds data.
    assign wr_en = we && (wn != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[wn] <= wd;
        end
    end

    assign rd_addr[0] = rs_addr;
    assign rd_addr[1] = rt_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] port_data;

            always_comb begin
                if (rd_addr[gi] == ZERO_IDX) begin
                    port_data = '0;
                end
`ifdef REGFILE_BYPASS_EN
                else if (wr_en && (rd_addr[gi] == wn)) begin
                    port_data = wd;
                end
`endif
                else begin
                    port_data = regs_reg[rd_addr[gi]];
                end
            end
        end
    endgenerate

    assign rs_data = g_rd[0].port_data;
    assign rt_data = g_rd[1].port_data;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, commit qualification, retired-write counter, register file.
// Build option REGFILE_BYPASS_EN enables same-cycle write-through on the read ports.
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_MemtoReg,
    input  logic              wb_RegWrite,
    input  logic [DATA_W-1:0] wb_ALUout,
    input  logic [DATA_W-1:0] wb_RD,
    input  logic [ADDR_W-1:0] wb_wn,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    output logic [CNT_W-1:0]  retire_cnt
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    wb_sel_t            wb_sel;
    logic               commit;
    logic               commit_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;

    assign wb_sel = wb_sel_t'(wb_MemtoReg);

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = wb_RD;
            default: wb_data = wb_ALUout;
        endcase
    end

    // RegWrite gates everything, so a don't-care wb_wn cannot produce a write.
    assign commit = wb_RegWrite && (wb_wn != ZERO_IDX);

    // Free-running wrap: the debug counter has no saturation.
    assign cnt_next = commit ? (cnt_reg + CNT_W'(1)) : cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            commit_reg <= commit;
            cnt_reg    <= cnt_next;
        end
    end

    assign wb_commit  = commit_reg;
    assign retire_cnt = cnt_reg;

    regfile_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .wn      (wb_wn),
        .wd      (wb_data),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, random traffic against a
// register-array model, counter wrap (CNT_W=4) and reset-with-commit sequences.
module tb_wb_regfile;

    localparam int CW = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          m2r;
    logic          rw;
    logic [31:0]   alu;
    logic [31:0]   rd;
    logic [4:0]    wn;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [31:0]   rs_data;
    logic [31:0]   rt_data;
    logic [31:0]   wb_data;
    logic          wb_commit;
    logic [CW-1:0] retire_cnt;

    wb_regfile #(
        .DATA_W(32),
        .ADDR_W(5),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_MemtoReg (m2r),
        .wb_RegWrite (rw),
        .wb_ALUout   (alu),
        .wb_RD       (rd),
        .wb_wn       (wn),
        .rs_addr     (rs),
        .rt_addr     (rt),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .wb_data     (wb_data),
        .wb_commit   (wb_commit),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of register values plus counters.
    logic [31:0]   m_regs [32];
    logic [CW-1:0] m_cnt;
    logic          m_commit;

    logic [31:0] act_wb;
    logic [31:0] act_rs;
    logic [31:0] act_rt;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] e_wb;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic        e_commit;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_wbdata();
        return m2r ? rd : alu;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && rw && (wn != 5'd0) && (a == wn)) return m_wbdata();
        return m_regs[a];
    endfunction

    task automatic drive(input logic r_w, input logic m_2r, input logic [31:0] a_lu,
                         input logic [31:0] r_d, input logic [4:0] w_n,
                         input logic [4:0] r_s, input logic [4:0] r_t);
        rw  = r_w;
        m2r = m_2r;
        alu = a_lu;
        rd  = r_d;
        wn  = w_n;
        rs  = r_s;
        rt  = r_t;
    endtask

    // One clock: sample combinational outputs at negedge, advance the model at posedge,
    // sample registered outputs 1 time unit later.
    task automatic step(input bit chk);
        @(negedge clk);
        act_wb = wb_data;
        act_rs = rs_data;
        act_rt = rt_data;
        if (chk) begin
            check("wb_data", act_wb, m_wbdata());
            check("rs_data", act_rs, m_read(rs));
            check("rt_data", act_rt, m_read(rt));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt    = '0;
            m_commit = 1'b0;
        end else begin
            m_commit = rw && (wn != 5'd0);
            if (m_commit) begin
                m_regs[wn] = m_wbdata();
                m_cnt      = m_cnt + 1'b1;
            end
        end
        #1;
        if (chk) begin
            check("wb_commit", 32'(wb_commit), 32'(m_commit));
            check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
        end
        $display("cyc rst=%0b rw=%0b m2r=%0b wn=%0d rs=%0d rt=%0d wb=%h rsd=%h rtd=%h commit=%0b cnt=%0d",
                 rst, rw, m2r, wn, rs, rt, act_wb, act_rs, act_rt, wb_commit, retire_cnt);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt    = '0;
        m_commit = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0,
                   32'h0000_1234, BYP ? 32'h0000_1234 : 32'h0, 32'h0, 1'b1, 4'd1};
        tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 5'd5, 5'd5, 5'd6,
                   32'h0, 32'h0000_1234, 32'h0, 1'b0, 4'd1};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_1111, 32'hDEAD_BEEF, 5'd6, 5'd5, 5'd6,
                   32'hDEAD_BEEF, 32'h0000_1234, BYP ? 32'hDEAD_BEEF : 32'h0, 1'b1, 4'd2};
        tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd6,
                   32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'd2};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6,
                   32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'd2};
        tbl[5] = '{1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 5'd7, 5'd7, 5'd7,
                   32'hA5A5_A5A5, BYP ? 32'hA5A5_A5A5 : 32'h0,
                   BYP ? 32'hA5A5_A5A5 : 32'h0, 1'b1, 4'd3};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5,
                   32'h0, 32'hA5A5_A5A5, 32'h0000_1234, 1'b0, 4'd3};

        // Reset with a pending write to index 9 that must be dropped.
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h1357_9BDF, 32'h0, 5'd9, 5'd0, 5'd0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        check("reset_commit", 32'(wb_commit), 32'h0);
        check("reset_cnt", 32'(retire_cnt), 32'h0);

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
            step(1'b0);
            check("reset_rs", act_rs, 32'h0);
            check("reset_rt", act_rt, 32'h0);
        end

        for (int v = 0; v < 7; v++) begin
            drive(tbl[v].rw, tbl[v].m2r, tbl[v].alu, tbl[v].rd, tbl[v].wn, tbl[v].rs, tbl[v].rt);
            step(1'b0);
            check($sformatf("vec%0d_wb", v), act_wb, tbl[v].e_wb);
            check($sformatf("vec%0d_rs", v), act_rs, tbl[v].e_rs);
            check($sformatf("vec%0d_rt", v), act_rt, tbl[v].e_rt);
            check($sformatf("vec%0d_commit", v), 32'(wb_commit), 32'(tbl[v].e_commit));
            check($sformatf("vec%0d_cnt", v), 32'(retire_cnt), 32'(tbl[v].e_cnt));
        end

        for (int n = 0; n < 300; n++) begin
            logic [4:0] w;
            w   = 5'($urandom);
            rst = ($urandom_range(0, 39) == 0);
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, w,
                  ($urandom_range(0, 3) == 0) ? w : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? w : 5'($urandom));
            step(1'b1);
        end
        rst = 1'b0;

        // Run the counter up to all-ones, then one more commit wraps it.
        for (int k = 0; k < 20 && m_cnt != 4'hF; k++) begin
            drive(1'b1, 1'b0, 32'(k), 32'h0, 5'd1, 5'd1, 5'd2);
            step(1'b1);
        end
        check("pre_wrap_cnt", 32'(retire_cnt), 32'hF);
        drive(1'b1, 1'b0, 32'h0000_00AA, 32'h0, 5'd2, 5'd1, 5'd2);
        step(1'b1);
        check("wrap_cnt", 32'(retire_cnt), 32'h0);

        drive(1'b1, 1'b0, 32'h0BAD_F00D, 32'h0, 5'd3, 5'd3, 5'd3);
        step(1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0077, 32'h0, 5'd3, 5'd0, 5'd0);
        step(1'b0);
        check("rstwr_cnt", 32'(retire_cnt), 32'h0);
        check("rstwr_commit", 32'(wb_commit), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
        step(1'b0);
        check("rstwr_rs", act_rs, 32'h0);
        check("rstwr_rt", act_rt, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
